// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline interlock and forwarding controller for the 5-stage MIPS core.
// Shadows the EX/MEM destinations, raises load-use and HI/LO stalls, and registers the EX forwarding selects.
module hazard_scoreboard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [5:0] id_rreg1,
  input  logic [5:0] id_rreg2,
  input  logic [5:0] id_wreg,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       flush,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       muldiv_busy
);

  localparam logic [5:0] REG_HILO = 6'd33;

  logic [5:0]       ex_dst_q, ex_dst_d, mem_dst_q;
  logic             ex_load_q, ex_load_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             load_use, md_hazard, advance;

  function automatic logic reg_match(input logic [5:0] r, input logic [5:0] dst);
    return (r != 6'd0) && (r == dst);
  endfunction

  // EX producer is younger than MEM, so it wins when both hold the same register.
  function automatic logic [1:0] fwd_sel(input logic [5:0] r, input logic [5:0] ex_d,
                                         input logic [5:0] mem_d);
    if (reg_match(r, ex_d))       return 2'd1;
    else if (reg_match(r, mem_d)) return 2'd2;
    else                          return 2'd0;
  endfunction

  assign muldiv_busy = (busy_cnt_q != '0);

  assign load_use  = id_valid & ex_load_q &
                     (reg_match(id_rreg1, ex_dst_q) | reg_match(id_rreg2, ex_dst_q));
  assign md_hazard = id_valid & muldiv_busy &
                     (id_is_muldiv | (id_rreg1 == REG_HILO) | (id_rreg2 == REG_HILO));

  assign stall_if_id = (load_use | md_hazard) & ~flush;
  assign bubble_ex   = stall_if_id | flush | ~id_valid;
  assign advance     = ~bubble_ex;

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // The busy counter alone records HI/LO occupancy; no separate EX mul/div flag is needed.
  always_comb begin
    ex_dst_d   = advance ? id_wreg : 6'd0;
    ex_load_d  = advance & id_is_load;
    fwd_a_d    = advance ? fwd_sel(id_rreg1, ex_dst_q, mem_dst_q) : 2'd0;
    fwd_b_d    = advance ? fwd_sel(id_rreg2, ex_dst_q, mem_dst_q) : 2'd0;
    busy_cnt_d = busy_cnt_q;
    if (advance && id_is_muldiv) begin
      busy_cnt_d = CNT_W'(MULDIV_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst_q   <= 6'd0;
      ex_load_q  <= 1'b0;
      mem_dst_q  <= 6'd0;
      busy_cnt_q <= '0;
      fwd_a_q    <= 2'd0;
      fwd_b_q    <= 2'd0;
    end else begin
      ex_dst_q   <= ex_dst_d;
      ex_load_q  <= ex_load_d;
      mem_dst_q  <= ex_dst_q;
      busy_cnt_q <= busy_cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

endmodule
